// File: rtl/wb_button.sv
// wb_button: debounced push-button / slide-switch block with a Wishbone slave
// register interface and a level interrupt.
//
// Ports:
//   clk        system clock; every flop rises on it
//   reset_n    synchronous active-low reset
//   wb_*_i     Wishbone slave inputs (adr, dat, sel, stb, cyc, we)
//   wb_dat_o   read data, valid only while wb_ack_o is high, zero otherwise
//   wb_ack_o   single-cycle acknowledge
//   btn_n      raw buttons, active-low, asynchronous
//   sw         raw slide switches, active-high, asynchronous
//   intr       registered |(EVENT & IRQEN)
//
// Register map (word address wb_adr_i[3:2]):
//   0 STATE  RO   [4:0] buttons, [11:8] switches
//   1 EVENT  W1C  [4:0] press, [20:16] release
//   2 IRQEN  RW   [4:0], [20:16]
//   3 reserved, reads 0
module wb_button #(
  parameter int unsigned clk_freq    = 100000000,
  parameter int unsigned debounce_us = 10000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  input  logic [4:0]  btn_n,
  input  logic [3:0]  sw,
  output logic        intr
);

  localparam int unsigned N        = clk_freq / 1000000 * debounce_us;
  localparam logic [23:0] CNT_LAST = 24'(N - 1);
  localparam logic [31:0] EV_MASK  = 32'h001F_001F;
  localparam int unsigned NUM_IN   = 9;

  typedef enum logic [1:0] {
    REG_STATE = 2'd0,
    REG_EVENT = 2'd1,
    REG_IRQEN = 2'd2,
    REG_RSVD  = 2'd3
  } reg_sel_t;

  // Synchronizers; button flops reset to the released (high) level.
  logic [4:0] btn_s1, btn_s2;
  logic [3:0] sw_s1, sw_s2;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      btn_s1 <= '1;
      btn_s2 <= '1;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      btn_s1 <= btn_n;
      btn_s2 <= btn_s1;
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
    end
  end

  // Bits 0..4 are buttons (active-high), bits 5..8 are switches.
  logic [NUM_IN-1:0] synced;
  logic [NUM_IN-1:0] stable;
  logic [NUM_IN-1:0] flip;
  logic [23:0]       cnt [NUM_IN];

  always_comb begin
    synced = {sw_s2, ~btn_s2};
    flip   = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      flip[i] = (synced[i] != stable[i]) && (cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stable <= '0;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        if (synced[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (flip[i]) begin
          stable[i] <= synced[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 24'd1;
        end
      end
    end
  end

  // Register file and Wishbone slave.
  logic [31:0] event_q, irqen_q;
  logic [31:0] event_set, event_clr, event_next, irqen_next;
  logic [31:0] lane_mask, rd_data;
  logic        wb_req, wb_wr;
  reg_sel_t    reg_sel;
  logic        unused_adr;

  assign unused_adr = ^{wb_adr_i[31:4], wb_adr_i[1:0]};

  always_comb begin
    reg_sel   = reg_sel_t'(wb_adr_i[3:2]);
    wb_req    = wb_stb_i & wb_cyc_i & ~wb_ack_o;
    wb_wr     = wb_req & wb_we_i;
    lane_mask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}},
                 {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    event_set = {11'd0, flip[4:0] & ~synced[4:0],
                 11'd0, flip[4:0] &  synced[4:0]};

    rd_data = '0;
    case (reg_sel)
      REG_STATE: rd_data = {20'd0, stable[8:5], 3'd0, stable[4:0]};
      REG_EVENT: rd_data = event_q;
      REG_IRQEN: rd_data = irqen_q;
      REG_RSVD:  rd_data = '0;
      default:   rd_data = '0;
    endcase

    event_clr = '0;
    if (wb_wr && reg_sel == REG_EVENT) begin
      event_clr = wb_dat_i & lane_mask & EV_MASK;
    end
    // Set is applied after clear so a coincident new event survives.
    event_next = (event_q & ~event_clr) | event_set;

    irqen_next = irqen_q;
    if (wb_wr && reg_sel == REG_IRQEN) begin
      irqen_next = ((irqen_q & ~lane_mask) | (wb_dat_i & lane_mask)) & EV_MASK;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      event_q  <= '0;
      irqen_q  <= '0;
      intr     <= 1'b0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      event_q  <= event_next;
      irqen_q  <= irqen_next;
      intr     <= |(event_q & irqen_q);
      wb_ack_o <= wb_req;
      wb_dat_o <= wb_req ? rd_data : '0;
    end
  end

endmodule

// File: tb/tb_wb_button.sv
// tb_wb_button: directed stimulus for wb_button (N = 10 debounce cycles) with
// a window-based reference model checked every cycle plus literal checks.
module tb_wb_button;

  localparam int unsigned N = 10;

  logic        clk;
  logic        reset_n;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic [4:0]  btn_n;
  logic [3:0]  sw;
  logic        intr;

  int n_checks = 0;
  int n_errors = 0;

  wb_button #(
    .clk_freq   (10000000),
    .debounce_us(1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i),
    .wb_sel_i(wb_sel_i),
    .wb_stb_i(wb_stb_i),
    .wb_cyc_i(wb_cyc_i),
    .wb_we_i (wb_we_i),
    .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o),
    .btn_n   (btn_n),
    .sw      (sw),
    .intr    (intr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: an input's stable level flips once its synchronized
  // value has disagreed with the stable level for the last N edges.
  logic [8:0]   m_d1, m_d2, m_stable;
  logic [N-1:0] m_win [9];
  logic [31:0]  m_event, m_irqen, m_dat;
  logic         m_ack, m_intr, m_valid = 1'b0;

  always @(posedge clk) begin
    logic        req;
    logic [31:0] rd, clr, setm, lanes;
    if (!reset_n) begin
      m_d1 = '0; m_d2 = '0; m_stable = '0;
      for (int i = 0; i < 9; i++) m_win[i] = '0;
      m_event = '0; m_irqen = '0; m_dat = '0; m_ack = 1'b0; m_intr = 1'b0;
      m_valid = 1'b1;
    end else begin
      req   = wb_stb_i && wb_cyc_i && !m_ack;
      lanes = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
      case (wb_adr_i[3:2])
        2'd0:    rd = {20'd0, m_stable[8:5], 3'd0, m_stable[4:0]};
        2'd1:    rd = m_event;
        2'd2:    rd = m_irqen;
        default: rd = 32'd0;
      endcase
      setm = '0;
      for (int i = 0; i < 9; i++) begin
        m_win[i] = {m_win[i][N-2:0], m_d2[i]};
        if (m_stable[i] ? (m_win[i] == '0) : (m_win[i] == '1)) begin
          m_stable[i] = ~m_stable[i];
          if (i < 5) setm[m_stable[i] ? i : i + 16] = 1'b1;
        end
      end
      clr = (req && wb_we_i && wb_adr_i[3:2] == 2'd1) ? (wb_dat_i & lanes & 32'h001F001F) : 32'd0;
      m_intr  = |(m_event & m_irqen);
      m_event = (m_event & ~clr) | setm;
      if (req && wb_we_i && wb_adr_i[3:2] == 2'd2)
        m_irqen = ((m_irqen & ~lanes) | (wb_dat_i & lanes)) & 32'h001F001F;
      m_dat = req ? rd : 32'd0;
      m_ack = req;
      m_d2  = m_d1;
      m_d1  = {sw, ~btn_n};
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check32("cyc_ack", {31'd0, wb_ack_o}, {31'd0, m_ack});
      check32("cyc_dat", wb_dat_o, m_dat);
      check32("cyc_intr", {31'd0, intr}, {31'd0, m_intr});
    end
  end

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rd);
    bit got = 0;
    @(negedge clk);
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
    for (int k = 0; k < 4 && !got; k++) begin
      @(negedge clk);
      if (wb_ack_o) got = 1;
    end
    rd = wb_dat_o;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL ack_timeout: got no ack expected ack within 4 cycles");
    end
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] unused_rd;
    wb_xfer(1'b1, adr, dat, sel, unused_rd);
  endtask

  task automatic wb_read_check(input string name, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] rd;
    wb_xfer(1'b0, adr, 32'd0, 4'hF, rd);
    check32(name, rd, exp);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int acks;
    reset_n = 1'b0; btn_n = '1; sw = '0;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;

    // Reset state
    wait_cycles(3);
    check32("rst_ack", {31'd0, wb_ack_o}, 32'd0);
    check32("rst_dat", wb_dat_o, 32'd0);
    check32("rst_intr", {31'd0, intr}, 32'd0);
    reset_n = 1'b1;
    wb_read_check("rst_state", 32'h0, 32'h0);
    wb_read_check("rst_event", 32'h4, 32'h0);
    wb_read_check("rst_irqen", 32'h8, 32'h0);

    // Short glitch on button 2 is filtered
    @(negedge clk); btn_n[2] = 1'b0;
    wait_cycles(6); btn_n[2] = 1'b1;
    wait_cycles(30);
    wb_read_check("glitch_state", 32'h0, 32'h0);
    wb_read_check("glitch_event", 32'h4, 32'h0);
    check32("glitch_intr", {31'd0, intr}, 32'd0);

    // Press with interrupt enabled, exact latency, then W1C
    wb_write(32'h8, 32'h0000_0004, 4'hF);
    @(negedge clk); btn_n[2] = 1'b0;
    wait_cycles(12);
    check32("press_intr_edge12", {31'd0, intr}, 32'd0);
    wait_cycles(1);
    check32("press_intr_edge13", {31'd0, intr}, 32'd1);
    wb_read_check("press_state", 32'h0, 32'h4);
    wb_read_check("press_event", 32'h4, 32'h4);
    wb_write(32'h4, 32'h0000_0004, 4'hF);
    wb_read_check("w1c_event", 32'h4, 32'h0);
    check32("w1c_intr", {31'd0, intr}, 32'd0);

    // Press and release of button 0 with interrupts disabled
    wb_write(32'h8, 32'h0, 4'hF);
    @(negedge clk); btn_n[0] = 1'b0;
    wait_cycles(15); btn_n[0] = 1'b1;
    wait_cycles(15);
    wb_read_check("release_event", 32'h4, 32'h0001_0001);
    check32("release_intr", {31'd0, intr}, 32'd0);

    // Set wins over a coincident W1C
    wb_write(32'h4, 32'hFFFF_FFFF, 4'hF);
    @(negedge clk); btn_n[1] = 1'b0;
    wait_cycles(15); btn_n[1] = 1'b1;
    wait_cycles(15);
    wb_write(32'h4, 32'hFFFF_FFFF, 4'hF);
    @(negedge clk); btn_n[1] = 1'b0;
    wait_cycles(10);
    wb_write(32'h4, 32'h0000_0002, 4'hF);
    wb_read_check("setwins_event", 32'h4, 32'h0000_0002);

    // Switches: STATE boundary at edge 12, no events, reserved word
    btn_n = '1;
    wait_cycles(15);
    wb_write(32'h4, 32'hFFFF_FFFF, 4'hF);
    @(negedge clk); sw = 4'b1010;
    wait_cycles(10);
    wb_read_check("sw_state_edge12", 32'h0, 32'h0);
    wb_read_check("sw_state_later", 32'h0, 32'h0000_0A00);
    wb_read_check("sw_event", 32'h4, 32'h0);
    wb_read_check("rsvd_read", 32'hC, 32'h0);
    @(negedge clk);
    check32("rsvd_ack_single", {31'd0, wb_ack_o}, 32'd0);

    // Back-to-back strobe: ack every second cycle
    @(negedge clk);
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h0;
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (wb_ack_o) acks++;
    end
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    check32("b2b_acks", acks, 32'd3);

    // Byte lanes on IRQEN and EVENT
    wb_write(32'h8, 32'h001F_001F, 4'b0100);
    wb_read_check("lane2_irqen", 32'h8, 32'h001F_0000);
    wb_write(32'h8, 32'h001F_001F, 4'b0001);
    wb_read_check("lane0_irqen", 32'h8, 32'h001F_001F);
    @(negedge clk); btn_n[3] = 1'b0;
    wait_cycles(15); btn_n[3] = 1'b1;
    wait_cycles(15);
    wb_write(32'h4, 32'hFFFF_FFFF, 4'b0001);
    wb_read_check("lane0_w1c", 32'h4, 32'h0008_0000);
    wb_write(32'h4, 32'hFFFF_FFFF, 4'b0100);

    // Strobe without cycle is ignored
    @(negedge clk);
    wb_stb_i = 1'b1; wb_cyc_i = 1'b0; wb_we_i = 1'b1; wb_adr_i = 32'h8; wb_dat_i = 32'h0;
    acks = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (wb_ack_o) acks++;
    end
    wb_stb_i = 1'b0; wb_we_i = 1'b0;
    check32("nocyc_acks", acks, 32'd0);
    wb_read_check("nocyc_irqen", 32'h8, 32'h001F_001F);

    // Reset during a write to IRQEN
    @(negedge clk);
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 32'h8; wb_dat_i = 32'h0000_0003; wb_sel_i = 4'hF;
    reset_n = 1'b0;
    @(negedge clk);
    check32("rstwr_ack", {31'd0, wb_ack_o}, 32'd0);
    check32("rstwr_dat", wb_dat_o, 32'd0);
    check32("rstwr_intr", {31'd0, intr}, 32'd0);
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    reset_n = 1'b1;
    wb_read_check("rstwr_irqen", 32'h8, 32'h0);

    // Button held across reset, reset mid-debounce
    @(negedge clk); btn_n[4] = 1'b0;
    wait_cycles(5);
    reset_n = 1'b0;
    wait_cycles(2);
    reset_n = 1'b1;
    wb_write(32'h8, 32'h0000_0010, 4'hF);
    wait_cycles(10);
    check32("held_intr_edge12", {31'd0, intr}, 32'd0);
    wait_cycles(1);
    check32("held_intr_edge13", {31'd0, intr}, 32'd1);
    wb_read_check("held_event", 32'h4, 32'h0000_0010);

    wait_cycles(2);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
